playlist_ctrl: RTL

Sequencer that owns the song reader's `song` select, `play` enable and reset. It turns three front-panel button pulses (play/pause, next, prev) into song loads, pause/resume and track skips. It advances through the playlist on `song_done`, inserting a beat-counted silence gap between tracks. It sits between the button debouncers / beat generator and the song reader.

---
 rtl/playlist_ctrl.sv | 209 ++++++++++++++++++++
 1 files changed

// File: rtl/playlist_ctrl.sv
// Playlist sequencer: turns play/next/prev button pulses and song_done into song
// select, play enable and reader reset, with a beat-counted gap between songs.
// Optional shuffle order is enabled with `define SHUFFLE_EN.
module playlist_ctrl #(
    parameter int NUM_SONGS = 4,
    parameter int GAP_BEATS = 4
) (
    input  logic       i_clk,
    input  logic       i_reset_n,
    input  logic       i_btn_play,
    input  logic       i_btn_next,
    input  logic       i_btn_prev,
    input  logic       i_repeat_all,
`ifdef SHUFFLE_EN
    input  logic       i_shuffle,
`endif
    input  logic       i_beat,
    input  logic       i_song_done,
    output logic [1:0] o_song,
    output logic       o_play,
    output logic       o_reader_reset,
    output logic       o_playlist_done,
    output logic [2:0] o_state_dbg
);

    localparam int IDX_W = 2;
    localparam int GAP_W = $clog2(GAP_BEATS + 1);

    localparam logic [2:0] S_IDLE  = 3'd0;
    localparam logic [2:0] S_LOAD  = 3'd1;
    localparam logic [2:0] S_PLAY  = 3'd2;
    localparam logic [2:0] S_PAUSE = 3'd3;
    localparam logic [2:0] S_GAP   = 3'd4;

    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NUM_SONGS - 1);
    localparam logic [GAP_W-1:0] GAP_LAST = GAP_W'(GAP_BEATS - 1);

    logic [2:0]       r_state;
    logic [IDX_W-1:0] r_idx;
    logic [GAP_W-1:0] r_gap_cnt;
    logic             r_load_cnt;
    logic             r_playlist_done;

    logic [2:0]       w_state_next;
    logic [IDX_W-1:0] w_idx_next;
    logic [GAP_W-1:0] w_gap_next;
    logic             w_load_next;
    logic             w_done_next;
    logic             w_gap_end;

    logic [IDX_W-1:0] w_inc;
    logic [IDX_W-1:0] w_dec;
    logic [IDX_W-1:0] w_next_pick;
    logic [IDX_W-1:0] w_gap_pick;
    logic             w_gap_stop;

    assign w_inc = (r_idx == LAST_IDX) ? '0 : IDX_W'(r_idx + 1'b1);
    assign w_dec = (r_idx == '0) ? LAST_IDX : IDX_W'(r_idx - 1'b1);

`ifdef SHUFFLE_EN
    logic [7:0]       r_lfsr;
    logic [2:0]       r_played;
    logic [IDX_W-1:0] w_rand;
    logic [IDX_W-1:0] w_shuf_pick;
    logic             w_lfsr_fb;

    // Fibonacci taps 8,6,5,4
    assign w_lfsr_fb   = r_lfsr[7] ^ r_lfsr[5] ^ r_lfsr[4] ^ r_lfsr[3];
    assign w_rand      = IDX_W'(32'(r_lfsr[1:0]) % NUM_SONGS);
    assign w_shuf_pick = (w_rand == r_idx) ? w_inc : w_rand;
    assign w_next_pick = i_shuffle ? w_shuf_pick : w_inc;
    assign w_gap_pick  = i_shuffle ? w_shuf_pick : w_inc;
    assign w_gap_stop  = i_shuffle
                       ? (!i_repeat_all && (32'(r_played) + 1 >= NUM_SONGS))
                       : (!i_repeat_all && (r_idx == LAST_IDX));

    always_ff @(posedge i_clk or negedge i_reset_n) begin
        if (!i_reset_n) begin
            r_lfsr   <= 8'hA5;
            r_played <= '0;
        end else begin
            r_lfsr <= {r_lfsr[6:0], w_lfsr_fb};
            if (r_state == S_IDLE && w_state_next == S_LOAD)
                r_played <= '0;
            else if (w_gap_end && r_played != 3'd7)
                r_played <= r_played + 3'd1;
        end
    end
`else
    assign w_next_pick = w_inc;
    assign w_gap_pick  = w_inc;
    assign w_gap_stop  = !i_repeat_all && (r_idx == LAST_IDX);
`endif

    // Priority next > prev > song_done > play; events a state ignores are not
    // considered present, so they never mask a lower-priority event.
    always_comb begin
        w_state_next = r_state;
        w_idx_next   = r_idx;
        w_gap_next   = r_gap_cnt;
        w_load_next  = r_load_cnt;
        w_done_next  = 1'b0;
        w_gap_end    = 1'b0;
        case (r_state)
            S_IDLE: begin
                if (i_btn_next)
                    w_idx_next = w_next_pick;
                else if (i_btn_prev)
                    w_idx_next = w_dec;
                else if (i_btn_play) begin
                    w_state_next = S_LOAD;
                    w_load_next  = 1'b0;
                end
            end
            S_LOAD: begin
                if (r_load_cnt) begin
                    w_state_next = S_PLAY;
                    w_load_next  = 1'b0;
                end else begin
                    w_load_next = 1'b1;
                end
            end
            S_PLAY: begin
                if (i_btn_next) begin
                    w_idx_next   = w_next_pick;
                    w_state_next = S_LOAD;
                    w_load_next  = 1'b0;
                end else if (i_btn_prev) begin
                    w_idx_next   = w_dec;
                    w_state_next = S_LOAD;
                    w_load_next  = 1'b0;
                end else if (i_song_done) begin
                    w_state_next = S_GAP;
                    w_gap_next   = '0;
                end else if (i_btn_play) begin
                    w_state_next = S_PAUSE;
                end
            end
            S_PAUSE: begin
                if (i_btn_next) begin
                    w_idx_next   = w_next_pick;
                    w_state_next = S_LOAD;
                    w_load_next  = 1'b0;
                end else if (i_btn_prev) begin
                    w_idx_next   = w_dec;
                    w_state_next = S_LOAD;
                    w_load_next  = 1'b0;
                end else if (i_btn_play) begin
                    w_state_next = S_PLAY;
                end
            end
            S_GAP: begin
                if (i_btn_next) begin
                    w_idx_next   = w_next_pick;
                    w_state_next = S_LOAD;
                    w_load_next  = 1'b0;
                end else if (i_btn_prev) begin
                    w_idx_next   = w_dec;
                    w_state_next = S_LOAD;
                    w_load_next  = 1'b0;
                end else if (i_btn_play) begin
                    w_state_next = S_IDLE;
                end else if (i_beat) begin
                    if (r_gap_cnt == GAP_LAST) begin
                        w_gap_end  = 1'b1;
                        w_gap_next = '0;
                        if (w_gap_stop) begin
                            w_idx_next   = '0;
                            w_state_next = S_IDLE;
                            w_done_next  = 1'b1;
                        end else begin
                            w_idx_next   = w_gap_pick;
                            w_state_next = S_LOAD;
                            w_load_next  = 1'b0;
                        end
                    end else begin
                        w_gap_next = GAP_W'(r_gap_cnt + 1'b1);
                    end
                end
            end
            default: begin
                w_state_next = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge i_clk or negedge i_reset_n) begin
        if (!i_reset_n) begin
            r_state         <= S_IDLE;
            r_idx           <= '0;
            r_gap_cnt       <= '0;
            r_load_cnt      <= 1'b0;
            r_playlist_done <= 1'b0;
        end else begin
            r_state         <= w_state_next;
            r_idx           <= w_idx_next;
            r_gap_cnt       <= w_gap_next;
            r_load_cnt      <= w_load_next;
            r_playlist_done <= w_done_next;
        end
    end

    assign o_song          = r_idx;
    assign o_play          = (r_state == S_PLAY);
    assign o_reader_reset  = (r_state == S_IDLE) || (r_state == S_LOAD);
    assign o_playlist_done = r_playlist_done;
    assign o_state_dbg     = r_state;

endmodule
